// File: rtl/block_lut_arbiter.sv
// 64x1 lookup table with one registered read port shared round-robin between NREQ lanes.
// Define LUT_AUTOCLEAR_EN to zero the table after every reset (busy high during the sweep).
module block_lut_arbiter #(
  parameter int NREQ = 4,
  parameter int AW   = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ*AW-1:0] idx,
  output logic [NREQ-1:0]    gnt,
  output logic [NREQ-1:0]    rvalid,
  output logic               R,
  input  logic               cfg_we,
  input  logic [AW-1:0]      cfg_addr,
  input  logic               cfg_data,
  output logic               busy
);

  localparam int DEPTH = 2**AW;
  localparam int PW    = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic            block [DEPTH];
  logic [PW-1:0]   ptr;
  logic [PW-1:0]   gnt_idx;
  logic [PW-1:0]   lane;
  logic            hit;
  logic            arb_en;
  logic            grant;
  logic [AW-1:0]   sel_idx;
  logic            mem_we;
  logic [AW-1:0]   mem_wa;
  logic            mem_wd;

`ifdef LUT_AUTOCLEAR_EN
  typedef enum logic {CLEAR, SERVE} state_t;

  state_t        state;
  logic [AW-1:0] clr_addr;

  // busy is the registered decode of the state, so it doubles as the state probe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= CLEAR;
      clr_addr <= '0;
      busy     <= 1'b1;
    end else begin
      case (state)
        CLEAR: begin
          clr_addr <= clr_addr + 1'b1;
          if (clr_addr == AW'(DEPTH-1)) begin
            state <= SERVE;
            busy  <= 1'b0;
          end
        end
        SERVE: begin
          state <= SERVE;
        end
        default: begin
          state <= SERVE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  assign mem_we = ~rst & (busy | cfg_we);
  assign mem_wa = busy ? clr_addr : cfg_addr;
  assign mem_wd = busy ? 1'b0 : cfg_data;
`else
  assign busy   = 1'b0;
  assign mem_we = ~rst & cfg_we;
  assign mem_wa = cfg_addr;
  assign mem_wd = cfg_data;
`endif

  // Table storage is deliberately outside the reset domain.
  always_ff @(posedge clk) begin
    if (mem_we) block[mem_wa] <= mem_wd;
  end

  // Handshake: req is held until gnt; gnt is same-cycle, and the read completes
  // on the following cycle with rvalid one-hot on the granted lane and data on R.
  assign arb_en = ~rst & ~busy & ~cfg_we;

  always_comb begin
    hit     = 1'b0;
    gnt_idx = ptr;
    lane    = '0;
    for (int i = 1; i <= NREQ; i++) begin
      lane = PW'((int'(ptr) + i) % NREQ);
      if (!hit && req[lane]) begin
        hit     = 1'b1;
        gnt_idx = lane;
      end
    end
  end

  assign grant = arb_en & hit;

  always_comb begin
    gnt     = '0;
    sel_idx = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (gnt_idx == PW'(k)) begin
        gnt[k]  = grant;
        sel_idx = idx[AW*k +: AW];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rvalid <= '0;
      R      <= 1'b0;
      ptr    <= PW'(NREQ-1);
    end else begin
      rvalid <= gnt;
      if (grant) begin
        R   <= block[sel_idx];
        ptr <= gnt_idx;
      end
    end
  end

endmodule

// File: tb/tb_block_lut_arbiter.sv
// Directed bench for block_lut_arbiter: vector table plus reset, clear and round-robin sequences.
module tb_block_lut_arbiter;

  localparam int NREQ = 4;
  localparam int AW   = 6;

  logic               clk;
  logic               rst;
  logic [NREQ-1:0]    req;
  logic [NREQ*AW-1:0] idx;
  logic [NREQ-1:0]    gnt;
  logic [NREQ-1:0]    rvalid;
  logic               R;
  logic               cfg_we;
  logic [AW-1:0]      cfg_addr;
  logic               cfg_data;
  logic               busy;

  block_lut_arbiter #(.NREQ(NREQ), .AW(AW)) dut (
    .clk(clk), .rst(rst), .req(req), .idx(idx), .gnt(gnt), .rvalid(rvalid), .R(R),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  req;
    logic [23:0] idx;
    logic        we;
    logic [5:0]  addr;
    logic        dat;
    logic [3:0]  e_gnt;
    logic [3:0]  e_rv;
    logic        e_r;
  } vec_t;

  vec_t vecs[23];
  logic exp_tbl [64];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [23:0] li(input logic [5:0] a3, input logic [5:0] a2,
                                     input logic [5:0] a1, input logic [5:0] a0);
    return {a3, a2, a1, a0};
  endfunction

  task automatic wait_clear(input logic [3:0] rq, input logic we);
    int cnt;
    cnt = 0;
    req = rq; cfg_we = we; cfg_addr = '0; cfg_data = 1'b1;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (!busy) break;
      cnt++;
      chk($sformatf("gnt_while_busy_%0d", cnt), 32'(gnt), 32'd0);
    end
    req = '0; cfg_we = 1'b0;
    chk("busy_cycles", cnt, 64);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [5:0] lidx [4];
    lidx = '{6'd5, 6'd0, 6'd20, 6'd63};

    vecs[0]  = '{4'b0100, li(0,5,0,0),    1'b0, 6'd0, 1'b0, 4'b0100, 4'b0000, 1'b0};
    vecs[1]  = '{4'b0100, li(0,62,0,0),   1'b0, 6'd0, 1'b0, 4'b0100, 4'b0100, 1'b1};
    vecs[2]  = '{4'b0100, li(0,63,0,0),   1'b0, 6'd0, 1'b0, 4'b0100, 4'b0100, 1'b0};
    vecs[3]  = '{4'b0000, li(0,0,0,0),    1'b0, 6'd0, 1'b0, 4'b0000, 4'b0100, 1'b1};
    vecs[4]  = '{4'b0000, li(0,0,0,0),    1'b0, 6'd0, 1'b0, 4'b0000, 4'b0000, 1'b1};
    vecs[5]  = '{4'b1111, li(63,20,0,5),  1'b0, 6'd0, 1'b0, 4'b1000, 4'b0000, 1'b1};
    vecs[6]  = '{4'b1111, li(63,20,0,5),  1'b0, 6'd0, 1'b0, 4'b0001, 4'b1000, 1'b1};
    vecs[7]  = '{4'b1111, li(63,20,0,5),  1'b0, 6'd0, 1'b0, 4'b0010, 4'b0001, 1'b1};
    vecs[8]  = '{4'b1111, li(63,20,0,5),  1'b0, 6'd0, 1'b0, 4'b0100, 4'b0010, 1'b0};
    vecs[9]  = '{4'b1111, li(63,20,0,5),  1'b0, 6'd0, 1'b0, 4'b1000, 4'b0100, 1'b1};
    vecs[10] = '{4'b1111, li(63,20,0,5),  1'b0, 6'd0, 1'b0, 4'b0001, 4'b1000, 1'b1};
    vecs[11] = '{4'b1111, li(63,20,0,5),  1'b0, 6'd0, 1'b0, 4'b0010, 4'b0001, 1'b1};
    vecs[12] = '{4'b1111, li(63,20,0,5),  1'b0, 6'd0, 1'b0, 4'b0100, 4'b0010, 1'b0};
    vecs[13] = '{4'b0001, li(0,0,0,0),    1'b0, 6'd0, 1'b0, 4'b0001, 4'b0100, 1'b1};
    vecs[14] = '{4'b0010, li(0,0,9,0),    1'b1, 6'd9, 1'b1, 4'b0000, 4'b0001, 1'b0};
    vecs[15] = '{4'b0010, li(0,0,9,0),    1'b0, 6'd0, 1'b0, 4'b0010, 4'b0000, 1'b0};
    vecs[16] = '{4'b0000, li(0,0,0,0),    1'b0, 6'd0, 1'b0, 4'b0000, 4'b0010, 1'b1};
    vecs[17] = '{4'b1000, li(0,0,0,0),    1'b0, 6'd0, 1'b0, 4'b1000, 4'b0000, 1'b1};
    vecs[18] = '{4'b0100, li(0,5,0,0),    1'b0, 6'd0, 1'b0, 4'b0100, 4'b1000, 1'b0};
    vecs[19] = '{4'b1001, li(63,0,0,0),   1'b0, 6'd0, 1'b0, 4'b1000, 4'b0100, 1'b1};
    vecs[20] = '{4'b1001, li(63,0,0,0),   1'b0, 6'd0, 1'b0, 4'b0001, 4'b1000, 1'b1};
    vecs[21] = '{4'b0000, li(0,0,0,0),    1'b0, 6'd0, 1'b0, 4'b0000, 4'b0001, 1'b0};
    vecs[22] = '{4'b0000, li(0,0,0,0),    1'b0, 6'd0, 1'b0, 4'b0000, 4'b0000, 1'b0};

    // Reset values
    rst = 1'b1; req = '0; idx = '0; cfg_we = 1'b0; cfg_addr = '0; cfg_data = 1'b0;
    #12;
    chk("reset_gnt", 32'(gnt), 32'd0);
    chk("reset_rvalid", 32'(rvalid), 32'd0);
    chk("reset_R", 32'(R), 32'd0);
`ifdef LUT_AUTOCLEAR_EN
    chk("reset_busy", 32'(busy), 32'd1);
`else
    chk("reset_busy", 32'(busy), 32'd0);
`endif
    @(posedge clk); #1;
    rst = 1'b0;

`ifdef LUT_AUTOCLEAR_EN
    // Clear sweep with a competing write and requests that must both be ignored
    wait_clear(4'b1111, 1'b1);
    for (int a = 0; a <= 64; a++) begin
      @(posedge clk); #1;
      req = (a < 64) ? 4'b0001 : 4'b0000;
      idx = li(0, 0, 0, 6'(a));
      @(negedge clk);
      if (a < 64) chk($sformatf("clr_gnt_%0d", a), 32'(gnt), 32'd1);
      if (a > 0) begin
        chk($sformatf("clr_rvalid_%0d", a-1), 32'(rvalid), 32'd1);
        chk($sformatf("clr_R_%0d", a-1), 32'(R), 32'd0);
      end
    end
`endif

    // Load the whole table: ones at 5, 20, 63
    for (int a = 0; a < 64; a++) begin
      @(posedge clk); #1;
      req = '0;
      cfg_we = 1'b1; cfg_addr = 6'(a); cfg_data = (a == 5 || a == 20 || a == 63);
      exp_tbl[a] = cfg_data;
    end

    for (int n = 0; n < 23; n++) begin
      @(posedge clk); #1;
      req = vecs[n].req; idx = vecs[n].idx;
      cfg_we = vecs[n].we; cfg_addr = vecs[n].addr; cfg_data = vecs[n].dat;
      if (vecs[n].we) exp_tbl[vecs[n].addr] = vecs[n].dat;
      @(negedge clk);
      chk($sformatf("row%0d_gnt", n), 32'(gnt), 32'(vecs[n].e_gnt));
      chk($sformatf("row%0d_rvalid", n), 32'(rvalid), 32'(vecs[n].e_rv));
      chk($sformatf("row%0d_R", n), 32'(R), 32'(vecs[n].e_r));
    end

    // Reset while a read is in flight
    @(posedge clk); #1;
    cfg_we = 1'b0; req = 4'b0001; idx = li(0, 0, 0, 6'd5);
    @(negedge clk);
    chk("pre_rst_gnt", 32'(gnt), 32'd1);
    @(posedge clk); #1;
    chk("pre_rst_rvalid", 32'(rvalid), 32'd1);
    chk("pre_rst_R", 32'(R), 32'(exp_tbl[5]));
    rst = 1'b1;
    #1;
    chk("mid_rst_gnt", 32'(gnt), 32'd0);
    chk("mid_rst_rvalid", 32'(rvalid), 32'd0);
    chk("mid_rst_R", 32'(R), 32'd0);
`ifdef LUT_AUTOCLEAR_EN
    chk("mid_rst_busy", 32'(busy), 32'd1);
`endif
    @(posedge clk); #1;
    chk("held_rst_rvalid", 32'(rvalid), 32'd0);
    rst = 1'b0; req = '0;
`ifdef LUT_AUTOCLEAR_EN
    wait_clear(4'b1111, 1'b0);
    for (int a = 0; a < 64; a++) exp_tbl[a] = 1'b0;
`endif

    // Round-robin from the reset pointer: lane 0 wins first
    for (int i = 0; i <= 5; i++) begin
      @(posedge clk); #1;
      req = (i < 5) ? 4'b1111 : 4'b0000;
      idx = li(6'd63, 6'd20, 6'd0, 6'd5);
      @(negedge clk);
      if (i < 5) chk($sformatf("rr_gnt_%0d", i), 32'(gnt), 32'(1) << (i % 4));
      if (i > 0) begin
        chk($sformatf("rr_rvalid_%0d", i-1), 32'(rvalid), 32'(1) << ((i-1) % 4));
        chk($sformatf("rr_R_%0d", i-1), 32'(R), 32'(exp_tbl[lidx[(i-1) % 4]]));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
